// File: rtl/melody_seq.sv
// Note sequencer: plays a small writable score of {beats, divisor} entries as a
// stream of divisor words for a tone generator. Optional MELODY_SEQ_LOOP_EN repeats the song.
module melody_seq #(
  parameter int DW  = 16,
  parameter int AW  = 3,
  parameter int DUR = 10,
  parameter int GAP = 2,
  parameter int TW  = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW+3:0] wr_data,
  output logic [DW-1:0] div,
  output logic          note_stb,
  output logic [AW-1:0] idx,
  output logic          playing,
  output logic          done,
  output logic [1:0]    state_dbg
);

  // Control protocol: start is a single-cycle request honoured only in IDLE;
  // stop is a level that overrides start in every state; wr_en is accepted only in IDLE.

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_t;

  localparam int            LEN    = 2 ** AW;
  localparam logic [AW-1:0] LAST   = AW'(LEN - 1);
  localparam logic [TW-1:0] DUR_W  = TW'(DUR);
  localparam logic [TW-1:0] GAP_M1 = (GAP > 0) ? TW'(GAP - 1) : '0;

  state_t        state;
  logic [TW-1:0] cnt;
  logic [DW+3:0] mem [LEN];
  logic [DW+3:0] entry;
  logic [3:0]    entry_beats;
  logic [DW-1:0] entry_div;
  logic          adv_now;
  logic          end_now;

  assign entry       = mem[idx];
  assign entry_beats = entry[DW+3:DW];
  assign entry_div   = entry[DW-1:0];
  assign state_dbg   = state;

  // Score is frozen while playing; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    adv_now = 1'b0;
    case (state)
      S_NOTE:  adv_now = (cnt == '0) && (GAP == 0);
      S_GAP:   adv_now = (cnt == '0);
      default: adv_now = 1'b0;
    endcase
    end_now = ((state == S_LOAD) && (entry_beats == 4'd0)) || (adv_now && (idx == LAST));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div      <= '0;
      note_stb <= 1'b0;
      idx      <= '0;
      playing  <= 1'b0;
      done     <= 1'b0;
    end else begin
      note_stb <= 1'b0;
      done     <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        cnt     <= '0;
        div     <= '0;
        idx     <= '0;
        playing <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_LOAD;
              idx     <= '0;
              playing <= 1'b1;
            end
          end
          S_LOAD: begin
            if (entry_beats != 4'd0) begin
              div      <= entry_div;
              note_stb <= 1'b1;
              cnt      <= TW'(entry_beats) * DUR_W - TW'(1);
              state    <= S_NOTE;
            end
          end
          S_NOTE: begin
            cnt <= cnt - TW'(1);
            if (cnt == '0 && GAP > 0) begin
              div   <= '0;
              cnt   <= GAP_M1;
              state <= S_GAP;
            end
          end
          S_GAP: begin
            cnt <= cnt - TW'(1);
          end
          default: state <= S_IDLE;
        endcase

        // End-of-song and advance override whatever the state branch scheduled.
        if (end_now) begin
`ifdef MELODY_SEQ_LOOP_EN
          idx   <= '0;
          div   <= '0;
          state <= S_LOAD;
`else
          state   <= S_IDLE;
          cnt     <= '0;
          div     <= '0;
          idx     <= '0;
          playing <= 1'b0;
          done    <= 1'b1;
`endif
        end else if (adv_now) begin
          idx   <= idx + 1'b1;
          div   <= '0;
          state <= S_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq (DUR=10, GAP=2, AW=2, DW=16); outputs are sampled 1 time unit after each rising edge.
module tb_melody_seq;
  localparam int DW  = 16;
  localparam int AW  = 2;
  localparam int DUR = 10;
  localparam int GAP = 2;
  localparam int TW  = 24;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW+3:0] wr_data = '0;
  logic [DW-1:0] div;
  logic          note_stb;
  logic [AW-1:0] idx;
  logic          playing;
  logic          done;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  melody_seq #(.DW(DW), .AW(AW), .DUR(DUR), .GAP(GAP), .TW(TW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .div(div), .note_stb(note_stb), .idx(idx), .playing(playing),
    .done(done), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [3:0] b, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {b, d};
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if (div !== 16'd0 || playing !== 1'b0 || idx !== 2'd0 || note_stb !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL reset_values got div=%0d playing=%0b idx=%0d stb=%0b done=%0b st=%0d exp all zero",
               div, playing, idx, note_stb, done, state_dbg);
    else n_pass++;
    rstn = 1'b1;
    tick();
  endtask

  // Scoreboard: expected div per cycle after start, built from hand-computed segments.
  task automatic test_play_song();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e;
    logic          exp_stb;
    logic [AW-1:0] exp_idx;
    int seg_v[7] = '{0, 4, 0, 3, 0, 2, 0};
    int seg_n[7] = '{1, 10, 3, 20, 3, 10, 15};
    for (int s = 0; s < 7; s++)
      for (int j = 0; j < seg_n[s]; j++) exp_q.push_back(DW'(seg_v[s]));
    pulse_start();
    for (int k = 1; k <= 62; k++) begin
      e       = exp_q.pop_front();
      exp_stb = (k == 2) || (k == 15) || (k == 38) || (k == 51);
      exp_idx = (k < 14) ? 2'd0 : (k < 37) ? 2'd1 : (k < 50) ? 2'd2 : 2'd3;
      n_checks++;
      if (div !== e) $display("FAIL play_div k=%0d got %0d exp %0d", k, div, e);
      else n_pass++;
      n_checks++;
      if (note_stb !== exp_stb) $display("FAIL play_stb k=%0d got %0b exp %0b", k, note_stb, exp_stb);
      else n_pass++;
      n_checks++;
      if (idx !== exp_idx) $display("FAIL play_idx k=%0d got %0d exp %0d", k, idx, exp_idx);
      else n_pass++;
      n_checks++;
      if (playing !== 1'b1 || done !== 1'b0)
        $display("FAIL play_status k=%0d got playing=%0b done=%0b exp 1/0", k, playing, done);
      else n_pass++;
      start = (k == 20);
      tick();
    end
    start = 1'b0;
`ifdef MELODY_SEQ_LOOP_EN
    n_checks++;
    if (idx !== 2'd0 || playing !== 1'b1 || done !== 1'b0 || div !== 16'd0)
      $display("FAIL loop_wrap got idx=%0d playing=%0b done=%0b div=%0d exp 0/1/0/0", idx, playing, done, div);
    else n_pass++;
    tick();
    n_checks++;
    if (div !== 16'd4 || note_stb !== 1'b1)
      $display("FAIL loop_replay got div=%0d stb=%0b exp 4/1", div, note_stb);
    else n_pass++;
    pulse_stop();
`else
    n_checks++;
    if (done !== 1'b1 || playing !== 1'b0 || idx !== 2'd0 || div !== 16'd0 || state_dbg !== 2'd0)
      $display("FAIL song_end got done=%0b playing=%0b idx=%0d div=%0d st=%0d exp 1/0/0/0/0",
               done, playing, idx, div, state_dbg);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_width got %0b exp 0", done);
    else n_pass++;
`endif
  endtask

  task automatic test_end_marker();
    write_entry(2'd1, 4'd0, 16'd3);
    pulse_start();
    for (int k = 1; k < 14; k++) tick();
    n_checks++;
    if (idx !== 2'd1 || playing !== 1'b1 || done !== 1'b0 || div !== 16'd0)
      $display("FAIL marker_load got idx=%0d playing=%0b done=%0b div=%0d exp 1/1/0/0", idx, playing, done, div);
    else n_pass++;
    tick();
`ifdef MELODY_SEQ_LOOP_EN
    n_checks++;
    if (idx !== 2'd0 || playing !== 1'b1 || done !== 1'b0 || div !== 16'd0)
      $display("FAIL marker_loop got idx=%0d playing=%0b done=%0b div=%0d exp 0/1/0/0", idx, playing, done, div);
    else n_pass++;
    tick();
    n_checks++;
    if (div !== 16'd4 || note_stb !== 1'b1) $display("FAIL marker_loop_div got div=%0d stb=%0b exp 4/1", div, note_stb);
    else n_pass++;
    pulse_stop();
`else
    n_checks++;
    if (done !== 1'b1 || playing !== 1'b0 || idx !== 2'd0 || div !== 16'd0)
      $display("FAIL marker_end got done=%0b playing=%0b idx=%0d div=%0d exp 1/0/0/0", done, playing, idx, div);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL marker_done_width got %0b exp 0", done);
    else n_pass++;
`endif
    write_entry(2'd1, 4'd2, 16'd3);
  endtask

  task automatic test_stop();
    int done_seen;
    pulse_start();
    for (int k = 1; k < 35; k++) tick();
    n_checks++;
    if (idx !== 2'd1 || div !== 16'd0 || state_dbg !== 2'd3)
      $display("FAIL stop_pre got idx=%0d div=%0d st=%0d exp 1/0/3", idx, div, state_dbg);
    else n_pass++;
    pulse_stop();
    n_checks++;
    if (state_dbg !== 2'd0 || playing !== 1'b0 || idx !== 2'd0 || div !== 16'd0 || done !== 1'b0)
      $display("FAIL stop_idle got st=%0d playing=%0b idx=%0d div=%0d done=%0b exp 0/0/0/0/0",
               state_dbg, playing, idx, div, done);
    else n_pass++;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done !== 1'b0 || playing !== 1'b0) done_seen++;
      tick();
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL stop_quiet got %0d active cycles exp 0", done_seen);
    else n_pass++;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (playing !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL start_stop got playing=%0b st=%0d exp 0/0", playing, state_dbg);
    else n_pass++;
    tick();
    n_checks++;
    if (playing !== 1'b0 || div !== 16'd0 || state_dbg !== 2'd0)
      $display("FAIL start_stop_hold got playing=%0b div=%0d st=%0d exp 0/0/0", playing, div, state_dbg);
    else n_pass++;
  endtask

  task automatic test_write_locked();
    int found;
    pulse_start();
    for (int k = 1; k < 5; k++) tick();
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = {4'd1, 16'd9};
    tick();
    wr_en   = 1'b0;
    n_checks++;
    if (div !== 16'd4) $display("FAIL locked_now got div=%0d exp 4", div);
    else n_pass++;
    found = 0;
`ifdef MELODY_SEQ_LOOP_EN
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (note_stb === 1'b1 && idx === 2'd0) found = 1;
      else tick();
    end
    n_checks++;
    if (found == 0) $display("FAIL locked_wait got timeout exp wrap within 200 cycles");
    else n_pass++;
    n_checks++;
    if (div !== 16'd4) $display("FAIL locked_replay got div=%0d exp 4", div);
    else n_pass++;
    pulse_stop();
`else
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (done === 1'b1) found = 1;
      else tick();
    end
    n_checks++;
    if (found == 0) $display("FAIL locked_wait got timeout exp done within 200 cycles");
    else n_pass++;
    pulse_start();
    tick();
    n_checks++;
    if (div !== 16'd4 || note_stb !== 1'b1) $display("FAIL locked_replay got div=%0d stb=%0b exp 4/1", div, note_stb);
    else n_pass++;
    pulse_stop();
`endif
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int k = 1; k < 5; k++) tick();
    n_checks++;
    if (div !== 16'd4 || playing !== 1'b1) $display("FAIL areset_pre got div=%0d playing=%0b exp 4/1", div, playing);
    else n_pass++;
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (div !== 16'd0 || playing !== 1'b0 || idx !== 2'd0 || state_dbg !== 2'd0)
      $display("FAIL areset_async got div=%0d playing=%0b idx=%0d st=%0d exp 0/0/0/0", div, playing, idx, state_dbg);
    else n_pass++;
    tick();
    rstn = 1'b1;
    tick();
    pulse_start();
    tick();
    n_checks++;
    if (div !== 16'd4) $display("FAIL areset_score_kept got div=%0d exp 4", div);
    else n_pass++;
    pulse_stop();
  endtask

  initial begin
    test_reset();
    write_entry(2'd0, 4'd1, 16'd4);
    write_entry(2'd1, 4'd2, 16'd3);
    write_entry(2'd2, 4'd1, 16'd2);
    write_entry(2'd3, 4'd1, 16'd0);
    tick();
    test_play_song();
    tick();
    test_end_marker();
    tick();
    test_stop();
    tick();
    test_write_locked();
    tick();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
